// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed 4-digit seven-segment display controller.
// A phase accumulator produces the scan tick; each tick rotates the active
// anode to the next enabled digit. New display contents arrive over a
// valid/ready port into a one-entry pending slot and are promoted to the
// active registers only on a frame-boundary tick, so a frame never mixes
// two values. All anode/segment/dp outputs are registered and active-low.
module disp_scan_ctrl #(
  parameter int ACC_WIDTH = 26,
  parameter int STEP      = 160,
  parameter bit LZB       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_val,
  input  logic [3:0]  in_mask,
  input  logic [3:0]  in_dp,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        upd_done,
  output logic        scan_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [ACC_WIDTH:0] STEP_EXT = (ACC_WIDTH + 1)'(STEP);

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next enabled digit above idx (wrapping). A single enabled digit returns
  // itself; an empty mask simply steps by one.
  function automatic logic [1:0] next_digit(input logic [1:0] idx,
                                            input logic [3:0] mask);
    logic [1:0] res;
    logic [1:0] cand;
    logic       found;
    res   = idx + 2'd1;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = idx + 2'(i);
      if (!found && mask[cand]) begin
        res   = cand;
        found = 1'b1;
      end else begin
        res   = res;
      end
    end
    return res;
  endfunction

  // True when digit idx (>0) and every higher digit are zero.
  function automatic logic lead_zero(input logic [15:0] val,
                                     input logic [1:0]  idx);
    logic z;
    case (idx)
      2'd1:    z = (val[15:4]  == 12'h000);
      2'd2:    z = (val[15:8]  == 8'h00);
      2'd3:    z = (val[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   acc_sum_s;
  logic                 tick_q, tick_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           nidx_s;
  logic                 boundary_s;
  logic [3:0]           nib_s;
  logic [15:0]          act_val_q, act_val_d;
  logic [3:0]           act_mask_q, act_mask_d;
  logic [3:0]           act_dp_q, act_dp_d;
  logic                 pend_full_q, pend_full_d;
  logic [15:0]          pend_val_q, pend_val_d;
  logic [3:0]           pend_mask_q, pend_mask_d;
  logic [3:0]           pend_dp_q, pend_dp_d;
  logic                 upd_q, upd_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  // Scan-rate accumulator; the carry out becomes next cycle's scan tick.
  always_comb begin
    acc_sum_s = {1'b0, acc_q} + STEP_EXT;
    acc_d     = acc_sum_s[ACC_WIDTH-1:0];
    tick_d    = acc_sum_s[ACC_WIDTH];
  end

  // Digit rotation, frame-boundary apply, pending capture and output decode.
  always_comb begin
    idx_d       = idx_q;
    act_val_d   = act_val_q;
    act_mask_d  = act_mask_q;
    act_dp_d    = act_dp_q;
    pend_full_d = pend_full_q;
    pend_val_d  = pend_val_q;
    pend_mask_d = pend_mask_q;
    pend_dp_d   = pend_dp_q;
    upd_d       = 1'b0;
    an_d        = an_q;
    seg_d       = seg_q;
    dp_d        = dp_q;
    nidx_s      = next_digit(idx_q, act_mask_q);
    boundary_s  = (nidx_s <= idx_q);

    // Apply only on a boundary tick; the slot is full so no capture can
    // happen in the same cycle.
    if (tick_q) begin
      idx_d = nidx_s;
      if (boundary_s && pend_full_q) begin
        act_val_d   = pend_val_q;
        act_mask_d  = pend_mask_q;
        act_dp_d    = pend_dp_q;
        pend_full_d = 1'b0;
        upd_d       = 1'b1;
      end else begin
        upd_d       = 1'b0;
      end
    end else begin
      idx_d = idx_q;
    end

    if (in_valid && !pend_full_q) begin
      pend_val_d  = in_val;
      pend_mask_d = in_mask;
      pend_dp_d   = in_dp;
      pend_full_d = 1'b1;
    end else begin
      pend_val_d  = pend_val_d;
    end

    // Outputs follow the post-tick digit and the (possibly new) active value.
    nib_s = act_val_d[{idx_d, 2'b00} +: 4];
    if (tick_q) begin
      if (!act_mask_d[idx_d]) begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
      end else if (LZB && lead_zero(act_val_d, idx_d)) begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = seg_decode(nib_s);
        dp_d  = ~act_dp_d[idx_d];
      end
    end else begin
      an_d  = an_q;
      seg_d = seg_q;
      dp_d  = dp_q;
    end
  end

  // State and output registers; reset blanks the display and drops pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      tick_q      <= 1'b0;
      idx_q       <= 2'd0;
      act_val_q   <= 16'h0000;
      act_mask_q  <= 4'hF;
      act_dp_q    <= 4'h0;
      pend_full_q <= 1'b0;
      pend_val_q  <= 16'h0000;
      pend_mask_q <= 4'h0;
      pend_dp_q   <= 4'h0;
      upd_q       <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      acc_q       <= acc_d;
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      act_val_q   <= act_val_d;
      act_mask_q  <= act_mask_d;
      act_dp_q    <= act_dp_d;
      pend_full_q <= pend_full_d;
      pend_val_q  <= pend_val_d;
      pend_mask_q <= pend_mask_d;
      pend_dp_q   <= pend_dp_d;
      upd_q       <= upd_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign in_ready  = ~pend_full_q;
  assign upd_done  = upd_q;
  assign scan_tick = tick_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: two instances (no blanking / leading-zero
// blanking) share stimulus; a cycle-level behavioural model predicts every
// output and each scenario task compares DUT against it every cycle.
module tb_disp_scan_ctrl;

  localparam int AW      = 4;
  localparam int STEP    = 4;
  localparam int ACC_MOD = 1 << AW;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  m;
    logic [3:0]  d;
  } item_t;

  logic        clk, reset;
  logic [15:0] in_val;
  logic [3:0]  in_mask, in_dp;
  logic        in_valid;
  logic        in_ready_n, upd_done_n, scan_tick_n, dp_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        in_ready_l, upd_done_l, scan_tick_l, dp_l;
  logic [3:0]  an_l;
  logic [6:0]  seg_l;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit idle_en = 1'b0;
  item_t send_q[$];

  // behavioural model state
  int          m_acc, m_idx;
  bit          m_tick, m_upd, m_pfull;
  logic [15:0] m_aval, m_pval;
  logic [3:0]  m_amask, m_adp, m_pmask, m_pdp;
  logic [11:0] m_out_n, m_out_l;

  disp_scan_ctrl #(.ACC_WIDTH(AW), .STEP(STEP), .LZB(1'b0)) u_dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_mask(in_mask),
    .in_dp(in_dp), .in_valid(in_valid), .in_ready(in_ready_n),
    .upd_done(upd_done_n), .scan_tick(scan_tick_n), .an(an_n),
    .seg(seg_n), .dp(dp_n));

  disp_scan_ctrl #(.ACC_WIDTH(AW), .STEP(STEP), .LZB(1'b1)) u_dut_lzb (
    .clk(clk), .reset(reset), .in_val(in_val), .in_mask(in_mask),
    .in_dp(in_dp), .in_valid(in_valid), .in_ready(in_ready_l),
    .upd_done(upd_done_l), .scan_tick(scan_tick_l), .an(an_l),
    .seg(seg_l), .dp(dp_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an, seg, dp} for digit idx of an active value.
  function automatic logic [11:0] m_disp(int idx, logic [15:0] v,
                                         logic [3:0] mk, logic [3:0] d, bit lzb);
    logic [3:0] a;
    int nib;
    if (!mk[idx]) return {4'hF, 7'h7F, 1'b1};
    a = 4'hF;
    a[idx] = 1'b0;
    nib = (int'(v) >> (4 * idx)) & 15;
    if (lzb && idx > 0 && (int'(v) >> (4 * idx)) == 0) return {a, 7'h7F, 1'b1};
    return {a, SEG_TAB[nib], ~d[idx]};
  endfunction

  function automatic int m_next(int idx, logic [3:0] mk);
    for (int i = 1; i <= 4; i++)
      if (mk[(idx + i) % 4]) return (idx + i) % 4;
    return (idx + 1) % 4;
  endfunction

  function automatic logic [29:0] observe();
    return {scan_tick_n, upd_done_n, in_ready_n, an_n, seg_n, dp_n,
            scan_tick_l, upd_done_l, in_ready_l, an_l, seg_l, dp_l};
  endfunction

  function automatic logic [29:0] expect_vec();
    return {m_tick, m_upd, ~m_pfull, m_out_n, m_tick, m_upd, ~m_pfull, m_out_l};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_idx = 0; m_tick = 0; m_upd = 0; m_pfull = 0;
    m_aval = 16'h0000; m_amask = 4'hF; m_adp = 4'h0;
    m_pval = 16'h0000; m_pmask = 4'h0; m_pdp = 4'h0;
    m_out_n = {4'hF, 7'h7F, 1'b1};
    m_out_l = {4'hF, 7'h7F, 1'b1};
  endtask

  // Drive one cycle of producer stimulus, advance the clock, update model.
  task automatic step();
    logic v;
    item_t it;
    bit carry, old_full;
    int nidx;
    v = 1'b0;
    it = item_t'({$urandom, $urandom});
    if (send_q.size() > 0 && (!idle_en || $urandom_range(3, 0) != 0)) begin
      v  = 1'b1;
      it = send_q[0];
    end
    in_valid = v; in_val = it.v; in_mask = it.m; in_dp = it.d;
    @(posedge clk);
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      old_full = m_pfull;
      carry = (m_acc + STEP) >= ACC_MOD;
      m_acc = (m_acc + STEP) % ACC_MOD;
      m_upd = 0;
      if (m_tick) begin
        nidx = m_next(m_idx, m_amask);
        if (nidx <= m_idx && m_pfull) begin
          m_aval = m_pval; m_amask = m_pmask; m_adp = m_pdp;
          m_pfull = 0; m_upd = 1;
        end
        m_idx = nidx;
        m_out_n = m_disp(m_idx, m_aval, m_amask, m_adp, 1'b0);
        m_out_l = m_disp(m_idx, m_aval, m_amask, m_adp, 1'b1);
      end
      if (v && !old_full) begin
        m_pval = it.v; m_pmask = it.m; m_pdp = it.d; m_pfull = 1;
        void'(send_q.pop_front());
      end
      m_tick = carry;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_val = 16'h0; in_mask = 4'h0; in_dp = 4'h0;
    model_reset();
    #12;
    n_tests++;
    if (observe() !== expect_vec()) begin
      n_fail++;
      $display("FAIL reset_hold obs=%h exp=%h", observe(), expect_vec());
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
  endtask

  task automatic test_scan();
    int ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (scan_tick_n) ticks++;
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL scan cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
    n_tests++;
    if (ticks !== 10) begin
      n_fail++;
      $display("FAIL scan_tick_rate got=%0d want=10", ticks);
    end
  endtask

  task automatic test_load();
    int upd_seen = 0;
    send_q.push_back('{16'h12AF, 4'hF, 4'b0100});
    for (int i = 0; i < 60; i++) begin
      step();
      if (upd_done_n) upd_seen++;
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL load cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
    n_tests++;
    if (upd_seen !== 1) begin
      n_fail++;
      $display("FAIL load_upd_count got=%0d want=1", upd_seen);
    end
  endtask

  task automatic test_mask_sparse();
    int bad = 0;
    send_q.push_back('{16'h4321, 4'b0101, 4'b0001});
    for (int i = 0; i < 60; i++) begin
      step();
      if (m_amask == 4'b0101 && (an_n == 4'b1101 || an_n == 4'b0111)) bad++;
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL mask_sparse cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mask_sparse_drive got=%0d want=0", bad);
    end
  endtask

  task automatic test_mask_zero();
    send_q.push_back('{16'hBEEF, 4'h0, 4'hF});
    for (int i = 0; i < 50; i++) begin
      step();
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL mask_zero cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int upd_seen = 0;
    int budget = 0;
    send_q.push_back('{16'hC0DE, 4'hF, 4'b1000});
    send_q.push_back('{16'h9876, 4'hF, 4'b0010});
    while ((send_q.size() > 0 || m_pfull) && budget < 300) begin
      step();
      budget++;
      if (upd_done_n) upd_seen++;
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
    n_tests++;
    if (budget >= 300 || upd_seen !== 2) begin
      n_fail++;
      $display("FAIL back_to_back_upd got=%0d want=2 budget=%0d", upd_seen, budget);
    end
  endtask

  task automatic test_lzb();
    send_q.push_back('{16'h0050, 4'hF, 4'h0});
    for (int i = 0; i < 50; i++) begin
      step();
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL lzb cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
  endtask

  task automatic test_random();
    int budget = 0;
    item_t it;
    idle_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      it = item_t'({$urandom, $urandom});
      if (k % 5 == 0) it.m = 4'h1 << $urandom_range(3, 0);
      send_q.push_back(it);
    end
    while ((send_q.size() > 0 || m_pfull) && budget < 3000) begin
      step();
      budget++;
      n_tests++;
      if (observe() !== expect_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
    idle_en = 1'b0;
    n_tests++;
    if (budget >= 3000) begin
      n_fail++;
      $display("FAIL random_timeout got=%0d want<3000", budget);
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    send_q.push_back('{16'h5A5A, 4'hF, 4'hF});
    while (!m_pfull && budget < 20) begin
      step();
      budget++;
    end
    n_tests++;
    if (!m_pfull || in_ready_n !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_pending in_ready=%b want=0", in_ready_n);
    end
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (observe() !== expect_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_async obs=%h exp=%h", observe(), expect_vec());
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_tests++;
      if (observe() !== expect_vec() || upd_done_n !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc=%0d obs=%h exp=%h", cyc, observe(), expect_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_mask_sparse();
    test_mask_zero();
    test_back_to_back();
    test_lzb();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
